mul_share_arb: RTL and testbench
================================

# mul_share_arb

Shared-multiplier front end. It arbitrates up to NREQ requesters onto a single pipelined 4x4 add-tree multiplier using round-robin order. Each result is buffered in a small output FIFO together with the index of the requester that issued it. Requesters see one valid/ready request port each, and the consumer sees a single valid/ready response port. Credit accounting guarantees that no multiplier result is ever dropped.

## Interface
- NREQ, 4: number of requesters (2..8)
- W, 4: operand width; product is 2W
- DEPTH, 4: response FIFO depth (power of 2, >=4)
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset rst, synchronous, active-high
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester accept (one-hot or zero)
- req_a  in  NREQ*W  operand A, requester i at [i*W +: W]
- req_b  in  NREQ*W  operand B, same packing
- rsp_valid  out  1  response FIFO non-empty
- rsp_ready  in  1  consumer pop
- rsp_id  out  $clog2(NREQ)  requester index of head result
- rsp_prod  out  2W  head product, unsigned
- stat_stall_cnt  out  16  present only with MUL_ARB_STATS_EN

## Operation
- Credit is available when fifo_count + s0_valid + s1_valid < DEPTH. A pop in the same cycle is not credited.
- Grant is combinational from the current state:
  - With credit available and any req_valid set, grant the first valid index at or after rr_ptr, wrapping modulo NREQ.
  - req_ready[g] = 1 for the granted index g only. All other bits are 0.
  - Without credit, req_ready is all zeros.
- Handshake: a transfer occurs when req_valid[i] & req_ready[i]. A requester holds its a/b stable while valid and unaccepted.
- rr_ptr moves to g+1 (mod NREQ) on a transfer. Otherwise it holds.
- Pipeline:
  - s0 registers a, b, id and the valid bit.
  - s1 registers two partial sums, again with id and valid:
    - w5 = pp0 + pp1
    - w6 = pp2 + pp3
    - ppk = b[k] ? (a << k) : 0, zero-extended to 2W.
  - The final sum w5 + w6 (2W bits, cannot overflow) is written with its id into the FIFO.
- The FIFO pops on rsp_valid & rsp_ready. rsp_id and rsp_prod are the head entry and hold while rsp_valid is high and rsp_ready is low.
- Write and pop in the same cycle keep fifo_count unchanged. Writing when full cannot occur; credit accounting guarantees this, and an assertion checks it.
- Reset values:
  - rsp_valid = 0, req_ready = 0.
  - rsp_id = 0, rsp_prod = 0 (FIFO storage cleared).
  - rr_ptr = 0, s0_valid = s1_valid = 0, fifo_count = 0.
  - stat_stall_cnt = 0.
- Reset mid-operation discards all in-flight and buffered results. No response is emitted for them.

## Timing
- A request accepted in cycle n gives earliest rsp_valid in cycle n+3.
- Throughput is one grant per cycle. With rsp_ready held high, DEPTH=4 sustains full rate (steady-state occupancy 3).
- Results leave in acceptance order. Order across requesters follows grant order.
- With rsp_ready low, at most DEPTH requests are accepted before req_ready drops to zero. Credit returns the cycle after a pop.

## Configuration
- MUL_ARB_STATS_EN defined: adds stat_stall_cnt.
  - Increments each cycle in which |req_valid is true and credit is not available.
  - Saturates at 16'hFFFF and clears on rst.
- Not defined: the port and counter are absent. Behaviour is otherwise identical.

## Structure
- Package mul_pkg holds:
  - Default widths.
  - The typedef for the pipeline stage record {valid, id, a, b / w5, w6}.
  - The function computing partial products.
- Sub-module mul_addtree_pipe holds the two-register add-tree (s0→s1→sum) carrying id alongside. The arbiter, credit logic and FIFO stay in mul_share_arb.

## Test plan
- Single request: req 2 issues a=15, b=15 in cycle n → rsp_valid in n+3, rsp_id=2, rsp_prod=225, single pulse with rsp_ready=1.
- All four requesters hold valid from reset with rsp_ready=1 → grants 0,1,2,3,0,... in consecutive cycles; products are correct and ids are in the same order.
- rsp_ready=0 with requests pending → exactly 4 accepts, then req_ready=0 and the head stays stable. Raising rsp_ready drains 4 results in order and grants resume one cycle after the first pop.
- Operand corners: a=0, b=9 gives 0; a=9, b=0 gives 0; a=1, b=1 gives 1; a=8, b=15 gives 120.
- Reset asserted while 2 results are in flight and 1 is buffered → next cycle rsp_valid=0, no stale responses afterwards, and the first grant after reset goes to requester 0.
- With MUL_ARB_STATS_EN: hold rsp_ready=0 and req_valid=1 for 10 cycles after the FIFO fills → stat_stall_cnt=10.

Source files
------------

// File: rtl/mul_pkg.sv
// mul_pkg: shared widths, pipeline stage records and partial-product helper
// for the shared multiplier front end.
package mul_pkg;
    localparam int NREQ_D = 4;
    localparam int W_D = 4;
    localparam int DEPTH_D = 4;
    localparam int IDW_D = $clog2(NREQ_D);

    typedef struct packed {
        logic valid;
        logic [IDW_D-1:0] id;
        logic [W_D-1:0] a;
        logic [W_D-1:0] b;
    } s0_t;

    typedef struct packed {
        logic valid;
        logic [IDW_D-1:0] id;
        logic [2*W_D-1:0] w5;
        logic [2*W_D-1:0] w6;
    } s1_t;

    function automatic logic [2*W_D-1:0] pp(input logic [W_D-1:0] a, input logic [W_D-1:0] b, input int k);
        return b[k] ? ({{W_D{1'b0}}, a} << k) : '0;
    endfunction
endpackage

// File: rtl/mul_addtree_pipe.sv
// mul_addtree_pipe: two-register add-tree multiplier (operands -> partial
// sums -> product), carrying the requester id alongside each stage.
module mul_addtree_pipe
    import mul_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             valid,
    input  logic [IDW_D-1:0] id,
    input  logic [W_D-1:0]   a,
    input  logic [W_D-1:0]   b,
    output logic             s0_valid,
    output logic             s1_valid,
    output logic             sum_valid,
    output logic [IDW_D-1:0] sum_id,
    output logic [2*W_D-1:0] sum
);
    s0_t s0;
    s1_t s1;
    logic [2*W_D-1:0] w5, w6;

    // Low half of the partial products feeds w5, high half feeds w6.
    always_comb begin
        w5 = '0;
        w6 = '0;
        for (int k = 0; k < W_D; k++)
            if (k < W_D / 2) w5 = w5 + pp(s0.a, s0.b, k);
            else w6 = w6 + pp(s0.a, s0.b, k);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s0 <= '0;
            s1 <= '0;
        end else begin
            s0 <= '{valid: valid, id: id, a: a, b: b};
            s1 <= '{valid: s0.valid, id: s0.id, w5: w5, w6: w6};
        end
    end

    assign s0_valid = s0.valid;
    assign s1_valid = s1.valid;
    assign sum_valid = s1.valid;
    assign sum_id = s1.id;
    assign sum = s1.w5 + s1.w6;
endmodule

// File: rtl/mul_share_arb.sv
// mul_share_arb: round-robin arbiter sharing one pipelined multiplier, with a
// credit-guarded response FIFO. MUL_ARB_STATS_EN adds stat_stall_cnt.
module mul_share_arb
    import mul_pkg::*;
#(
    parameter int NREQ = NREQ_D,
    parameter int W = W_D,
    parameter int DEPTH = DEPTH_D
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*W-1:0]       req_a,
    input  logic [NREQ*W-1:0]       req_b,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [$clog2(NREQ)-1:0] rsp_id,
    output logic [2*W-1:0]          rsp_prod
`ifdef MUL_ARB_STATS_EN
    ,
    output logic [15:0]             stat_stall_cnt
`endif
);
    localparam int IDW = $clog2(NREQ);
    localparam int AW = $clog2(DEPTH);

    logic [IDW-1:0] rr_ptr, g, sum_id;
    logic found, credit, xfer, push, pop, s0_valid, s1_valid;
    logic [W-1:0] op_a, op_b;
    logic [2*W-1:0] sum;
    logic [AW:0] count;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [IDW-1:0] mem_id [DEPTH];
    logic [2*W-1:0] mem_prod [DEPTH];

    // In-flight stages hold a FIFO slot in advance, so a push never finds it full.
    assign credit = int'(count) + int'(s0_valid) + int'(s1_valid) < DEPTH;

    // Walk downward so the nearest valid index at/after rr_ptr wins last.
    always_comb begin
        found = 1'b0;
        g = rr_ptr;
        for (int i = NREQ - 1; i >= 0; i--)
            if (req_valid[(int'(rr_ptr) + i) % NREQ]) begin
                found = 1'b1;
                g = IDW'((int'(rr_ptr) + i) % NREQ);
            end
    end

    assign xfer = found && credit;
    assign req_ready = xfer ? {{(NREQ-1){1'b0}}, 1'b1} << g : '0;
    assign op_a = req_a[g*W +: W];
    assign op_b = req_b[g*W +: W];
    assign pop = rsp_valid && rsp_ready;
    assign rsp_valid = count != '0;
    assign rsp_id = mem_id[rd_ptr];
    assign rsp_prod = mem_prod[rd_ptr];

    mul_addtree_pipe u_pipe (
        .clk       (clk),
        .rst       (rst),
        .valid     (xfer),
        .id        (g),
        .a         (op_a),
        .b         (op_b),
        .s0_valid  (s0_valid),
        .s1_valid  (s1_valid),
        .sum_valid (push),
        .sum_id    (sum_id),
        .sum       (sum)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
            count <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_id[i] <= '0;
                mem_prod[i] <= '0;
            end
        end else begin
            if (xfer) rr_ptr <= (int'(g) == NREQ - 1) ? '0 : g + IDW'(1);
            if (push) begin
                assert (count != (AW+1)'(DEPTH));
                mem_id[wr_ptr] <= sum_id;
                mem_prod[wr_ptr] <= sum;
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

`ifdef MUL_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) stat_stall_cnt <= '0;
        else if (|req_valid && !credit && stat_stall_cnt != 16'hFFFF) stat_stall_cnt <= stat_stall_cnt + 16'd1;
    end
`endif
endmodule

// File: tb/tb_mul_share_arb.sv
// tb_mul_share_arb: table-driven single-request vectors plus hand-written
// round-robin, backpressure, mid-flight reset and stall-counter sequences.
module tb_mul_share_arb;
    localparam int NREQ = 4;
    localparam int W = 4;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [NREQ-1:0] req_valid = '0;
    logic [NREQ-1:0] req_ready;
    logic [NREQ*W-1:0] req_a = '0;
    logic [NREQ*W-1:0] req_b = '0;
    logic rsp_valid;
    logic rsp_ready = 1'b0;
    logic [$clog2(NREQ)-1:0] rsp_id;
    logic [2*W-1:0] rsp_prod;
`ifdef MUL_ARB_STATS_EN
    logic [15:0] stat_stall_cnt;
`endif

    int pass_cnt = 0;
    int total_cnt = 0;

    typedef struct {
        int id;
        int a;
        int b;
        int prod;
    } vec_t;

    vec_t vecs[8];

    always #5 clk = ~clk;

    mul_share_arb #(.NREQ(NREQ), .W(W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_prod  (rsp_prod)
`ifdef MUL_ARB_STATS_EN
        ,
        .stat_stall_cnt (stat_stall_cnt)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    initial begin
        int acc;
        logic stale;
        vecs[0] = '{2, 15, 15, 225};
        vecs[1] = '{0, 0, 9, 0};
        vecs[2] = '{1, 9, 0, 0};
        vecs[3] = '{3, 1, 1, 1};
        vecs[4] = '{2, 8, 15, 120};
        vecs[5] = '{1, 7, 6, 42};
        vecs[6] = '{0, 13, 11, 143};
        vecs[7] = '{3, 5, 10, 50};

        repeat (2) @(negedge clk);
        check("reset_rsp_valid", 32'(rsp_valid), 0);
        check("reset_req_ready", 32'(req_ready), 0);
        check("reset_rsp_id", 32'(rsp_id), 0);
        check("reset_rsp_prod", 32'(rsp_prod), 0);
        rst = 1'b0;
        rsp_ready = 1'b1;

        // Isolated requests: latency 3, single-cycle response pulse.
        for (int i = 0; i < 8; i++) begin
            req_a[vecs[i].id*W +: W] = W'(vecs[i].a);
            req_b[vecs[i].id*W +: W] = W'(vecs[i].b);
            req_valid = '0;
            req_valid[vecs[i].id] = 1'b1;
            #1;
            check("vec_ready", 32'(req_ready), 32'(1 << vecs[i].id));
            @(negedge clk);
            req_valid = '0;
            check("vec_lat1", 32'(rsp_valid), 0);
            @(negedge clk);
            check("vec_lat2", 32'(rsp_valid), 0);
            @(negedge clk);
            check("vec_valid", 32'(rsp_valid), 1);
            check("vec_id", 32'(rsp_id), 32'(vecs[i].id));
            check("vec_prod", 32'(rsp_prod), 32'(vecs[i].prod));
            @(negedge clk);
            check("vec_pulse", 32'(rsp_valid), 0);
        end

        // Round robin at full rate from reset.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*W +: W] = W'(i + 2);
            req_b[i*W +: W] = W'(i + 3);
        end
        req_valid = '1;
        for (int c = 0; c < 11; c++) begin
            if (c == 8) req_valid = '0;
            #1;
            if (c < 8) check("rr_grant", 32'(req_ready), 32'(1 << (c % 4)));
            if (c >= 3) begin
                check("rr_valid", 32'(rsp_valid), 1);
                check("rr_id", 32'(rsp_id), 32'((c - 3) % 4));
                check("rr_prod", 32'(rsp_prod), 32'(((c - 3) % 4 + 2) * ((c - 3) % 4 + 3)));
            end
            @(negedge clk);
        end

        // Backpressure: exactly DEPTH accepts, then drain in order.
        rsp_ready = 1'b0;
        req_valid = '1;
        acc = 0;
        for (int k = 0; k < 8; k++) begin
            #1;
            if (req_ready != '0) begin
                check("bp_grant", 32'(req_ready), 32'(1 << (acc % 4)));
                acc++;
            end
            @(negedge clk);
        end
        check("bp_accepts", 32'(acc), 4);
        check("bp_ready_zero", 32'(req_ready), 0);
        check("bp_head_id", 32'(rsp_id), 0);
        check("bp_head_prod", 32'(rsp_prod), 6);
        rsp_ready = 1'b1;
        #1;
        check("bp_no_same_cycle_credit", 32'(req_ready), 0);
        for (int d = 0; d < 4; d++) begin
            check("bp_drain_valid", 32'(rsp_valid), 1);
            check("bp_drain_id", 32'(rsp_id), 32'(d));
            check("bp_drain_prod", 32'(rsp_prod), 32'((d + 2) * (d + 3)));
            if (d == 1) begin
                check("bp_resume", 32'(req_ready), 1);
                req_valid = '0;
            end
            @(negedge clk);
        end
        check("bp_empty", 32'(rsp_valid), 0);

        // Reset with one result buffered and two in flight.
        rsp_ready = 1'b0;
        req_valid = '1;
        repeat (3) @(negedge clk);
        req_valid = '0;
        check("rst_pre_valid", 32'(rsp_valid), 1);
        rst = 1'b1;
        @(negedge clk);
        check("rst_valid", 32'(rsp_valid), 0);
        check("rst_prod", 32'(rsp_prod), 0);
        rst = 1'b0;
        rsp_ready = 1'b1;
        stale = 1'b0;
        repeat (6) begin
            @(negedge clk);
            stale = stale | rsp_valid;
        end
        check("rst_no_stale", 32'(stale), 0);
        req_valid = '1;
        #1;
        check("rst_first_grant", 32'(req_ready), 1);
        @(negedge clk);
        req_valid = '0;
        repeat (4) @(negedge clk);

`ifdef MUL_ARB_STATS_EN
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("stat_reset", 32'(stat_stall_cnt), 0);
        rsp_ready = 1'b0;
        req_valid = '1;
        repeat (14) @(negedge clk);
        check("stat_stall", 32'(stat_stall_cnt), 10);
        req_valid = '0;
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
